// File: rtl/calculator.sv
// Signed 3-bit add/subtract calculator: button-triggered result register and a two-digit
// multiplexed seven-segment readout. Define CALC_DEBOUNCE_EN to insert a button debouncer.
module calculator #(
  parameter int REFRESH_BITS  = 17,
  parameter int DEBOUNCE_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       subtract,
  input  logic       calc_button,
  output logic [2:0] result,
  output logic       overflow,
  output logic [6:0] seg,
  output logic [7:0] an
);

  if (REFRESH_BITS < 1 || DEBOUNCE_BITS < 1) begin : g_bad_params
    $error("calculator: REFRESH_BITS and DEBOUNCE_BITS must both be at least 1");
  end

  logic r_sync1;
  logic r_sync2;
  logic r_level_prev;
  logic w_level;
  logic w_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_level_prev <= 1'b0;
    end else begin
      r_sync1      <= calc_button;
      r_sync2      <= r_sync1;
      r_level_prev <= w_level;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  logic                     r_deb;
  logic [DEBOUNCE_BITS-1:0] r_deb_cnt;

  // The level flips only after 2^DEBOUNCE_BITS consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_sync2 != r_deb) begin
      if (&r_deb_cnt) begin
        r_deb     <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end else begin
      r_deb_cnt <= '0;
    end
  end

  assign w_level = r_deb;
`else
  assign w_level = r_sync2;
`endif

  assign w_edge = w_level & ~r_level_prev;

  logic [2:0] w_b_eff;
  logic [2:0] w_sum;
  logic       w_ovf;

  assign w_b_eff = subtract ? ~b : b;
  assign w_sum   = a + w_b_eff + {2'b00, subtract};
  assign w_ovf   = subtract ? ((a[2] != b[2]) && (w_sum[2] != a[2]))
                            : ((a[2] == b[2]) && (w_sum[2] != a[2]));

  logic [2:0] r_result;
  logic       r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= 3'b000;
      r_overflow <= 1'b0;
    end else if (w_edge) begin
      r_result   <= w_sum;
      r_overflow <= w_ovf;
    end
  end

  assign result   = r_result;
  assign overflow = r_overflow;

  logic [REFRESH_BITS-1:0] r_scan;
  logic                    w_digit_sel;
  logic [2:0]              w_mag;
  logic [6:0]              w_seg_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= '0;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  assign w_digit_sel = r_scan[REFRESH_BITS-1];
  // Magnitude of -4 is 3'b100, which still reads correctly as 4.
  assign w_mag       = r_result[2] ? (~r_result + 3'd1) : r_result;

  always_comb begin
    w_seg_digit = 7'b1111111;
    case (w_mag)
      3'd0:    w_seg_digit = 7'b1000000;
      3'd1:    w_seg_digit = 7'b1111001;
      3'd2:    w_seg_digit = 7'b0100100;
      3'd3:    w_seg_digit = 7'b0110000;
      3'd4:    w_seg_digit = 7'b0011001;
      default: w_seg_digit = 7'b1111111;
    endcase
  end

  // Anode and segment data derive from the same registers, so they switch together.
  assign seg = w_digit_sel ? (r_result[2] ? 7'b0111111 : 7'b1111111) : w_seg_digit;
  assign an  = w_digit_sel ? 8'hFD : 8'hFE;

endmodule

// File: tb/tb_calculator.sv
// Self-checking bench for calculator: scoreboard of expected captures, display and reset checks.
module tb_calculator;

  localparam int RB = 4;
`ifdef CALC_DEBOUNCE_EN
  localparam int DB  = 3;
  localparam int DBC = 8;
`else
  localparam int DB  = 20;
  localparam int DBC = 0;
`endif
  localparam int LAT   = 3 + DBC;
  localparam int PRESS = 2 + DBC;
  localparam int GAP   = 4 + 2 * DBC;

  logic       clk;
  logic       rst;
  logic [2:0] a;
  logic [2:0] b;
  logic       subtract;
  logic       calc_button;
  logic [2:0] result;
  logic       overflow;
  logic [6:0] seg;
  logic [7:0] an;

  calculator #(.REFRESH_BITS(RB), .DEBOUNCE_BITS(DB)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .subtract(subtract),
    .calc_button(calc_button), .result(result), .overflow(overflow),
    .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] res;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive operands and push the arithmetic expectation for the next capture.
  task automatic set_ops(input int av, input int bv, input bit sub, input bit push);
    exp_t e;
    int   s;
    a        = av[2:0];
    b        = bv[2:0];
    subtract = sub;
    s        = sub ? av - bv : av + bv;
    e.res    = s[2:0];
    e.ovf    = (s < -4) || (s > 3);
    if (push) sb_q.push_back(e);
  endtask

  task automatic pulse_and_wait(input int len, input int edges);
    calc_button = 1'b1;
    for (int i = 1; i <= edges; i++) begin
      step(1);
      if (i == len) calc_button = 1'b0;
    end
  endtask

  task automatic wait_digit(input logic [7:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 ** RB + 4; i++) begin
      if (an == want) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  function automatic logic [6:0] digit0_seg(input logic [2:0] r);
    int v;
    v = r[2] ? int'(r) - 8 : int'(r);
    if (v < 0) v = -v;
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic capture_and_score(input string name, input logic [2:0] old_res);
    exp_t e;
    pulse_and_wait(PRESS, LAT - 1);
    checks++;
    if (result !== old_res) begin
      errors++;
      $display("FAIL %s_latency: result=%b before capture edge, required %b", name, result, old_res);
    end
    step(1);
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: queue empty, required one pending expectation", name);
    end else begin
      e = sb_q.pop_front();
      if (result !== e.res || overflow !== e.ovf) begin
        errors++;
        $display("FAIL %s: result=%b overflow=%b, required result=%b overflow=%b",
                 name, result, overflow, e.res, e.ovf);
      end
    end
    $display("txn %s: a=%0d b=%0d sub=%0b -> result=%b overflow=%b",
             name, $signed(a), $signed(b), subtract, result, overflow);
  endtask

  task automatic check_display(input string name, input logic [2:0] r);
    bit ok;
    logic [6:0] want1;
    want1 = r[2] ? 7'b0111111 : 7'b1111111;
    wait_digit(8'hFE, ok);
    checks++;
    if (!ok || seg !== digit0_seg(r)) begin
      errors++;
      $display("FAIL %s_digit0: an=%h seg=%b found=%0b, required an=fe seg=%b", name, an, seg, ok, digit0_seg(r));
    end
    wait_digit(8'hFD, ok);
    checks++;
    if (!ok || seg !== want1) begin
      errors++;
      $display("FAIL %s_digit1: an=%h seg=%b found=%0b, required an=fd seg=%b", name, an, seg, ok, want1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    calc_button = 1'b0;
    set_ops(1, 1, 1'b0, 1'b0);
    step(2);
    checks++;
    if (result !== 3'b000 || overflow !== 1'b0 || an !== 8'hFE || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL reset: result=%b overflow=%b an=%h seg=%b, required 000 0 fe 1000000",
               result, overflow, an, seg);
    end
    rst = 1'b0;
    step(GAP);
    checks++;
    if (result !== 3'b000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL idle_ops: result=%b overflow=%b, required 000 0", result, overflow);
    end
    $display("txn reset: result=%b overflow=%b an=%h seg=%b", result, overflow, an, seg);
  endtask

  task automatic test_add_overflow();
    set_ops(3, 2, 1'b0, 1'b1);
    capture_and_score("add_3_2", 3'b000);
    check_display("add_3_2", 3'b101);
    step(GAP);
  endtask

  task automatic test_subtract();
    set_ops(2, 3, 1'b1, 1'b1);
    capture_and_score("sub_2_3", 3'b101);
    set_ops(-1, -2, 1'b0, 1'b0);
    step(GAP);
    checks++;
    if (result !== 3'b111 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ops_no_press: result=%b overflow=%b, required 111 0", result, overflow);
    end
    set_ops(-4, 1, 1'b1, 1'b1);
    capture_and_score("sub_m4_1", 3'b111);
    check_display("sub_m4_1", 3'b011);
    step(GAP);
  endtask

  task automatic test_hold();
    exp_t e;
    int   changes;
    set_ops(-2, 3, 1'b0, 1'b0);
    calc_button = 1'b1;
    step(LAT - 1);
    set_ops(1, 1, 1'b0, 1'b1);
    step(1);
    e = sb_q.pop_front();
    checks++;
    if (result !== e.res || overflow !== e.ovf) begin
      errors++;
      $display("FAIL hold_capture: result=%b overflow=%b, required %b %b", result, overflow, e.res, e.ovf);
    end
    $display("txn hold_capture: result=%b overflow=%b", result, overflow);
    set_ops(3, 3, 1'b0, 1'b0);
    changes = 0;
    for (int i = 0; i < 50 - LAT; i++) begin
      step(1);
      if (result !== 3'b010 || overflow !== 1'b0) changes++;
    end
    calc_button = 1'b0;
    step(GAP);
    if (result !== 3'b010 || overflow !== 1'b0) changes++;
    checks++;
    if (changes !== 0) begin
      errors++;
      $display("FAIL hold_single: %0d cycles with changed output, required 0", changes);
    end
    set_ops(3, 3, 1'b0, 1'b1);
    capture_and_score("repress_3_3", 3'b010);
    step(GAP);
  endtask

  task automatic test_neg_and_reset_race();
    set_ops(-4, -4, 1'b0, 1'b1);
    capture_and_score("add_m4_m4", 3'b110);
    check_display("add_m4_m4", 3'b000);
    step(GAP);
    set_ops(3, 2, 1'b0, 1'b0);
    pulse_and_wait(PRESS, LAT - 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (result !== 3'b000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_race: result=%b overflow=%b, required 000 0", result, overflow);
    end
    step(GAP);
    checks++;
    if (result !== 3'b000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_race_after: result=%b overflow=%b, required 000 0", result, overflow);
    end
    $display("txn reset_race: result=%b overflow=%b", result, overflow);
  endtask

`ifdef CALC_DEBOUNCE_EN
  task automatic test_debounce();
    exp_t e;
    set_ops(1, 2, 1'b0, 1'b0);
    pulse_and_wait(4, 30);
    checks++;
    if (result !== 3'b000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL debounce_glitch: result=%b overflow=%b, required 000 0", result, overflow);
    end
    set_ops(1, 2, 1'b0, 1'b1);
    pulse_and_wait(20, LAT);
    e = sb_q.pop_front();
    checks++;
    if (result !== e.res || overflow !== e.ovf) begin
      errors++;
      $display("FAIL debounce_press: result=%b overflow=%b, required %b %b", result, overflow, e.res, e.ovf);
    end
    set_ops(-3, 3, 1'b1, 1'b0);
    pulse_and_wait(20 - LAT, 20 - LAT + GAP);
    checks++;
    if (result !== 3'b011 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL debounce_single: result=%b overflow=%b, required 011 0", result, overflow);
    end
    $display("txn debounce: result=%b overflow=%b", result, overflow);
  endtask
`endif

  initial begin
    test_reset();
    test_add_overflow();
    test_subtract();
    test_hold();
    test_neg_and_reset_race();
`ifdef CALC_DEBOUNCE_EN
    test_debounce();
`endif
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/calculator.md
# calculator

Signed 3-bit adder/subtractor with a button-triggered result register and a multiplexed seven-segment display driver. Operands `a`/`b` come from board switches; a press of `calc_button` captures `a+b` or `a-b` with a two's-complement overflow flag. The registered result drives the `result`/`overflow` outputs and a two-digit signed decimal readout on an 8-digit common-anode display.

## Interface
- `REFRESH_BITS`, default 17: width of the display scan counter. Its MSB selects the active digit.
- `DEBOUNCE_BITS`, default 20: debounce counter width. Used only with `CALC_DEBOUNCE_EN`.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `a` input 3: operand A, signed two's complement (-4..3).
- `b` input 3: operand B, signed two's complement.
- `subtract` input 1: 0 = A+B, 1 = A-B. Sampled at capture.
- `calc_button` input 1: asynchronous push button, active high.
- `result` output 3: registered signed result, wrapped to 3 bits.
- `overflow` output 1: registered signed-overflow flag for `result`.
- `seg` output 7: segment cathodes, active low. Bit order `seg[6:0]` = g,f,e,d,c,b,a.
- `an` output 8: digit anodes, active low. Only `an[0]` and `an[1]` are ever driven low.

## Operation
- **Button path**
  - `calc_button` passes through a 2-flop synchronizer, then a rising-edge detector (synced level AND NOT its previous value).
  - The edge pulse is exactly one cycle long. Holding the button gives exactly one capture. Release has no effect.
- **Capture**
  - On the edge pulse: `result <= (a ± b)[2:0]`. Subtract is computed as `a + ~b + 1`.
  - `overflow` <= 1 when the result sign differs from the true sign:
    - add: `a[2]==b[2]` and `sum[2]!=a[2]`;
    - subtract: `a[2]!=b[2]` and `diff[2]!=a[2]`.
  - Outside a capture, `result` and `overflow` hold their value. Operand changes alone do nothing.
- **Display**
  - The free-running scan counter selects the digit by its MSB.
  - Digit 0 (`an=8'hFE`) shows |result| (0..4).
  - Digit 1 (`an=8'hFD`) shows `-` (seg `7'b0111111`) when `result[2]=1`, otherwise blank (`7'b1111111`).
  - Digit patterns: 0 = `1000000`, 1 = `1111001`, 2 = `0100100`, 3 = `0110000`, 4 = `0011001`.
  - The display always shows the wrapped `result`. `overflow` has no effect on the display.
- **Reset**
  - Clears `result`, `overflow`, synchronizer/edge flops, scan counter and debounce state.
  - After reset: `an=8'hFE`, `seg=7'b1000000` (showing "0").
  - A reset asserted in the same cycle as an edge pulse wins; no capture occurs.

## Timing
- Button rises before rising edge k. Sync stage 1 captures at k, stage 2 at k+1.
- The edge pulse is high between k+1 and k+2. `result`/`overflow` update at edge k+2.
- Operands and `subtract` are sampled at edge k+2 only.
- Outputs are registered, with no combinational path from inputs to `result`/`overflow`.
- Each digit is active for 2^(REFRESH_BITS-1) cycles. `an` and `seg` change on the same edge, so there is no ghosting between digits.

## Configuration
- `CALC_DEBOUNCE_EN` defined:
  - A debouncer is inserted between the synchronizer and the edge detector.
  - The debounced level changes only after the synced input differs from it for 2^DEBOUNCE_BITS consecutive cycles. Any shorter glitch resets the counter.
  - Capture latency grows by 2^DEBOUNCE_BITS cycles.
- `CALC_DEBOUNCE_EN` undefined (default):
  - No debouncer; timing is as above.
  - A 2-cycle button pulse is sufficient to trigger a capture.

## Test plan
- Reset with `rst=1` for 2 cycles -> `result=0`, `overflow=0`, `an=FE`, `seg=1000000`.
- a=3, b=2, subtract=0, press 2 cycles -> at the 3rd edge after the press, `result=3'b101` (-3), `overflow=1`; digit 1 shows `-`, digit 0 shows `3`.
- a=2, b=3, subtract=1, press -> `result=3'b111`, `overflow=0`. Then a=-4, b=1, subtract=1, press -> `result=3'b011`, `overflow=1`.
- Hold button 50 cycles while changing a=1, b=1 mid-hold -> exactly one capture, using the operands present at the capture edge; no further update until release and re-press.
- a=-4, b=-4, add, press -> `result=0`, `overflow=1`, digit 1 blank. Asserting `rst` in the edge-pulse cycle -> no capture, outputs stay 0.
- With `CALC_DEBOUNCE_EN` and `DEBOUNCE_BITS=3`: 4-cycle press -> no capture; 20-cycle press -> one capture.
